// File: rtl/vend_pkg.sv
// Shared types and constants for the vending payment front end.
package vend_pkg;

    localparam int CREDIT_W = 5;
    localparam int PRICE_W  = 4;

    localparam logic [CREDIT_W-1:0] COIN_V1  = 5'd1;
    localparam logic [CREDIT_W-1:0] COIN_V2  = 5'd2;
    localparam logic [CREDIT_W-1:0] COIN_V5  = 5'd5;
    localparam logic [CREDIT_W-1:0] COIN_V10 = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_REFUND  = 2'd3
    } vend_state_e;

endpackage

// File: rtl/coin_accumulator_decode.sv
// Combinational coin_type to credit-unit translation.
module coin_decode
    import vend_pkg::*;
(
    input  logic [1:0]          coin_type_i,
    output logic [CREDIT_W-1:0] coin_value_o
);

    // Map the two-bit coin code onto its credit value.
    always_comb begin
        coin_value_o = COIN_V1;
        case (coin_type_i)
            2'b00:   coin_value_o = COIN_V1;
            2'b01:   coin_value_o = COIN_V2;
            2'b10:   coin_value_o = COIN_V5;
            2'b11:   coin_value_o = COIN_V10;
            default: coin_value_o = COIN_V1;
        endcase
    end

endmodule

// File: rtl/coin_accumulator.sv
// Credit accumulator and vend/refund sequencer feeding the payment comparator.
module coin_accumulator
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT     = 31,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid_i,
    input  logic [1:0]          coin_type_i,
    input  logic                cancel_i,
    input  logic                select_i,
    input  logic [PRICE_W-1:0]  price_i,
    input  logic                is_sufficient_i,
    input  logic                vend_ack_i,
    output logic [CREDIT_W-1:0] paid_o,
    output logic                coin_reject_o,
    output logic                deny_o,
    output logic                vend_req_o,
    output logic                change_valid_o,
    output logic [CREDIT_W-1:0] change_o,
    output logic                refund_valid_o
);

    localparam logic [CREDIT_W:0] MAX_CREDIT_W = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [TO_W-1:0]   TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);

    vend_state_e          state_q;
    logic [CREDIT_W-1:0]  paid_q;
    logic [CREDIT_W-1:0]  change_q;
    logic [PRICE_W-1:0]   price_q;
    logic [TO_W-1:0]      to_q;
    logic                 coin_reject_q;
    logic                 deny_q;
    logic                 vend_req_q;
    logic                 change_valid_q;
    logic                 refund_valid_q;

    logic [CREDIT_W-1:0]  coin_value_s;
    logic [CREDIT_W:0]    sum_d;
    logic                 fits_s;
    logic                 activity_s;
    logic                 timeout_s;

    coin_decode u_decode (
        .coin_type_i  (coin_type_i),
        .coin_value_o (coin_value_s)
    );

    // Six-bit sum so an overflowing coin is detected instead of wrapping.
    always_comb begin
        sum_d      = {1'b0, paid_q} + {1'b0, coin_value_s};
        fits_s     = (sum_d <= MAX_CREDIT_W);
        activity_s = coin_valid_i | select_i | cancel_i;
        timeout_s  = (to_q == TO_LAST);
    end

    // Sequencer: state, credit, timeout count and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            paid_q         <= 5'd0;
            change_q       <= 5'd0;
            price_q        <= 4'd0;
            to_q           <= '0;
            coin_reject_q  <= 1'b0;
            deny_q         <= 1'b0;
            vend_req_q     <= 1'b0;
            change_valid_q <= 1'b0;
            refund_valid_q <= 1'b0;
        end else begin
            coin_reject_q  <= 1'b0;
            deny_q         <= 1'b0;
            change_valid_q <= 1'b0;
            refund_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    to_q <= '0;
                    if (coin_valid_i) begin
                        paid_q  <= coin_value_s;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (timeout_s || cancel_i) begin
                        coin_reject_q <= coin_valid_i;
                        to_q          <= '0;
                        state_q       <= ST_REFUND;
                    end else if (select_i && is_sufficient_i) begin
                        coin_reject_q <= coin_valid_i;
                        price_q       <= price_i;
                        vend_req_q    <= 1'b1;
                        to_q          <= '0;
                        state_q       <= ST_VEND;
                    end else begin
                        deny_q <= select_i;
                        // Deny does not block a coin arriving in the same cycle.
                        if (coin_valid_i) begin
                            if (fits_s) begin
                                paid_q <= sum_d[CREDIT_W-1:0];
                            end else begin
                                coin_reject_q <= 1'b1;
                            end
                        end
                        to_q <= activity_s ? '0 : to_q + 1'b1;
                    end
                end
                ST_VEND: begin
                    coin_reject_q <= coin_valid_i;
                    if (vend_ack_i) begin
                        change_q       <= paid_q - {1'b0, price_q};
                        change_valid_q <= 1'b1;
                        paid_q         <= 5'd0;
                        vend_req_q     <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                ST_REFUND: begin
                    coin_reject_q  <= coin_valid_i;
                    change_q       <= paid_q;
                    refund_valid_q <= 1'b1;
                    paid_q         <= 5'd0;
                    state_q        <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    paid_q     <= 5'd0;
                    vend_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign paid_o         = paid_q;
    assign coin_reject_o  = coin_reject_q;
    assign deny_o         = deny_q;
    assign vend_req_o     = vend_req_q;
    assign change_valid_o = change_valid_q;
    assign change_o       = change_q;
    assign refund_valid_o = refund_valid_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed self-checking bench for coin_accumulator.
module tb_coin_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       cancel = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] price = 4'd0;
    logic       is_suff;
    logic       vend_ack = 1'b0;
    logic [4:0] paid;
    logic       coin_reject;
    logic       deny;
    logic       vend_req;
    logic       change_valid;
    logic [4:0] change;
    logic       refund_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int seen;

    always #5 clk = ~clk;

    // Comparator model: paid >= price.
    assign is_suff = ({1'b0, paid} >= {2'b00, price});

    coin_accumulator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .coin_valid_i    (coin_valid),
        .coin_type_i     (coin_type),
        .cancel_i        (cancel),
        .select_i        (sel),
        .price_i         (price),
        .is_sufficient_i (is_suff),
        .vend_ack_i      (vend_ack),
        .paid_o          (paid),
        .coin_reject_o   (coin_reject),
        .deny_o          (deny),
        .vend_req_o      (vend_req),
        .change_valid_o  (change_valid),
        .change_o        (change),
        .refund_valid_o  (refund_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given strobes held, then sample #1 after the edge.
    task automatic cyc(input logic cv, input logic [1:0] ct, input logic can,
                       input logic sl, input logic ack);
        coin_valid = cv; coin_type = ct; cancel = can; sel = sl; vend_ack = ack;
        @(posedge clk);
        #1;
        coin_valid = 1'b0; cancel = 1'b0; sel = 1'b0; vend_ack = 1'b0;
    endtask

    task automatic coin(input logic [1:0] ct);
        cyc(1'b1, ct, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        check("rst_paid", paid, 0);
        check("rst_vreq", vend_req, 0);
        check("rst_change", change, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // IDLE ignores select and cancel
        price = 4'd12;
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("idle_no_deny", deny, 0);

        // Vend with change
        coin(2'b11);
        check("paid10", paid, 10);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("deny_pulse", deny, 1);
        check("deny_vreq", vend_req, 0);
        coin(2'b10);
        check("deny_1cyc", deny, 0);
        check("paid15", paid, 15);
        coin(2'b01);
        check("paid17", paid, 17);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("vreq_on", vend_req, 1);
        idle();
        check("vreq_hold", vend_req, 1);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check("chg_valid", change_valid, 1);
        check("chg5", change, 5);
        check("paid0_vend", paid, 0);
        check("vreq_off", vend_req, 0);
        idle();
        check("chg_valid_1cyc", change_valid, 0);

        // Credit ceiling
        coin(2'b11); coin(2'b11); coin(2'b11);
        check("paid30", paid, 30);
        coin(2'b01);
        check("ovf_reject", coin_reject, 1);
        check("ovf_paid", paid, 30);
        coin(2'b00);
        check("no_reject", coin_reject, 0);
        check("paid31", paid, 31);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        idle();
        check("refund31", change, 31);

        // Cancel with a coin in the same cycle
        coin(2'b10); coin(2'b01);
        check("paid7", paid, 7);
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        check("cancel_reject", coin_reject, 1);
        idle();
        check("refund_valid", refund_valid, 1);
        check("refund7", change, 7);
        check("refund_paid0", paid, 0);
        idle();
        check("refund_1cyc", refund_valid, 0);
        check("chg_hold", change, 7);
        coin(2'b00);
        check("back_idle", paid, 1);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        idle();

        // Timeout, restarted by activity just before expiry
        price = 4'd15;
        coin(2'b01); coin(2'b00);
        check("paid3", paid, 3);
        seen = 0;
        for (int i = 0; i < 998; i++) begin
            idle();
            if (refund_valid) seen++;
        end
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("to_deny", deny, 1);
        for (int i = 0; i < 999; i++) begin
            idle();
            if (refund_valid) seen++;
        end
        check("to_early", seen, 0);
        idle();
        idle();
        check("to_refund", refund_valid, 1);
        check("to_change", change, 3);

        // VEND rejects coins and uses the latched price
        price = 4'd4;
        coin(2'b11);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("v2_vreq", vend_req, 1);
        coin(2'b00);
        check("vend_reject", coin_reject, 1);
        check("vend_paid", paid, 10);
        price = 4'd0;
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check("latched_chg", change, 6);

        // Reset while vending
        price = 4'd5;
        coin(2'b10);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("v3_vreq", vend_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vreq", vend_req, 0);
        check("arst_paid", paid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
            if (change_valid || vend_req) seen++;
        end
        check("arst_nopulse", seen, 0);
        coin(2'b00);
        check("arst_idle", paid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
